// File: rtl/video_frame_tx.sv
// video_frame_tx -- raster stream transmitter.
//
// Generates frame timing (vsync, vsync_neg_flag, o_de) and test-pattern pixel
// data on the same de/vsync_neg_flag/data interface the line-buffer and window
// blocks consume. Serves as a pattern source on hardware and as a bench driver.
//
// Ports:
//   clk             in   1   pixel clock
//   reset           in   1   synchronous reset, active-high
//   enable          in   1   level; request frames
//   mode            in   2   pattern select, sampled at frame start
//                            (0 h ramp, 1 v ramp, 2 8x8 checkerboard, 3 flat frame count)
//   vsync           out  1   vertical sync, active-high
//   vsync_neg_flag  out  1   1-clk pulse, first clk after vsync falls
//   o_de            out  1   active pixel strobe
//   dout            out  DW  pixel data, zero when o_de=0
//   busy            out  1   frame in progress
//   frame_done      out  1   1-clk pulse on last clk of each frame
//
// All outputs are registered and describe the raster position held in h_q/v_q.
// DW must not exceed 32.

module video_frame_tx #(
   parameter int unsigned DW       = 8,
   parameter int unsigned IW       = 1920,
   parameter int unsigned IH       = 1080,
   parameter int unsigned H_BLANK  = 280,
   parameter int unsigned V_BLANK  = 45,
   parameter int unsigned VS_LINES = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [1:0]    mode,
   output logic          vsync,
   output logic          vsync_neg_flag,
   output logic          o_de,
   output logic [DW-1:0] dout,
   output logic          busy,
   output logic          frame_done
);

   localparam int unsigned HT = IW + H_BLANK;
   localparam int unsigned VT = IH + V_BLANK;
   localparam int unsigned HW = $clog2(HT);
   localparam int unsigned VW = $clog2(VT);

   localparam logic [HW-1:0] H_MAX    = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(IW);
   localparam logic [VW-1:0] V_MAX    = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(IH);
   localparam logic [VW-1:0] V_VS_END = VW'(IH + VS_LINES);

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

   state_e        state_q;
   logic [HW-1:0] h_q, h_n;
   logic [VW-1:0] v_q, v_n;
   logic [1:0]    mode_q, mode_n;
   logic [DW-1:0] frame_cnt_q, cnt_n;
   logic [DW-1:0] flat_q, flat_n;
   logic [DW-1:0] pix_n;
   logic          at_end, in_frame, start, active_n, de_n;

   // Next raster position: everything registered below is a function of it,
   // so outputs line up with the counters.
   always_comb begin
      at_end   = (h_q == H_MAX) && (v_q == V_MAX);
      in_frame = (state_q != StIdle);
      // Only RUN chains frames back-to-back; STOP always drains to IDLE.
      start    = enable && ((state_q == StIdle) || ((state_q == StRun) && at_end));
      active_n = start || (in_frame && !at_end);

      h_n = '0;
      v_n = '0;
      if (active_n && !start) begin
         if (h_q == H_MAX) begin
            v_n = v_q + 1'b1;
         end else begin
            h_n = h_q + 1'b1;
            v_n = v_q;
         end
      end

      cnt_n  = (in_frame && at_end) ? frame_cnt_q + 1'b1 : frame_cnt_q;
      mode_n = start ? mode : mode_q;
      flat_n = start ? cnt_n : flat_q;
      de_n   = active_n && (h_n < H_ACT) && (v_n < V_ACT);

      case (mode_n)
         2'd0:    pix_n = DW'(h_n);
         2'd1:    pix_n = DW'(v_n);
         2'd2:    pix_n = (((32'(h_n) ^ 32'(v_n)) & 32'd8) != 32'd0) ? {DW{1'b1}} : '0;
         default: pix_n = flat_n;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         h_q            <= '0;
         v_q            <= '0;
         mode_q         <= '0;
         frame_cnt_q    <= '0;
         flat_q         <= '0;
         vsync          <= 1'b0;
         vsync_neg_flag <= 1'b0;
         o_de           <= 1'b0;
         dout           <= '0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: if (enable) state_q <= StRun;
            StRun: begin
               if (at_end)       state_q <= enable ? StRun : StIdle;
               else if (!enable) state_q <= StStop;
            end
            StStop:  if (at_end) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         h_q            <= h_n;
         v_q            <= v_n;
         mode_q         <= mode_n;
         frame_cnt_q    <= cnt_n;
         flat_q         <= flat_n;
         o_de           <= de_n;
         dout           <= de_n ? pix_n : '0;
         vsync          <= active_n && (v_n >= V_ACT) && (v_n < V_VS_END);
         vsync_neg_flag <= active_n && (v_n == V_VS_END) && (h_n == '0);
         busy           <= active_n;
         frame_done     <= active_n && (h_n == H_MAX) && (v_n == V_MAX);
      end
   end

endmodule

// File: tb/tb_video_frame_tx.sv
module tb_video_frame_tx;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [1:0] mode;
   logic       vsync, vsync_neg_flag, o_de, busy, frame_done;
   logic [7:0] dout;

   logic       reset2, enable2;
   logic [1:0] mode2;
   logic       vsync2, vsync_neg_flag2, o_de2, busy2, frame_done2;
   logic [7:0] dout2;

   int vectors = 0;
   int errors  = 0;
   logic [12:0] want;
   wire  [12:0] obs1 = {busy, frame_done, vsync, vsync_neg_flag, o_de, dout};
   wire  [12:0] obs2 = {busy2, frame_done2, vsync2, vsync_neg_flag2, o_de2, dout2};

   always #5 clk = ~clk;

   video_frame_tx #(
      .DW(8), .IW(8), .IH(4), .H_BLANK(4), .V_BLANK(3), .VS_LINES(1)
   ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .vsync(vsync), .vsync_neg_flag(vsync_neg_flag), .o_de(o_de), .dout(dout),
      .busy(busy), .frame_done(frame_done)
   );

   video_frame_tx #(
      .DW(8), .IW(16), .IH(16), .H_BLANK(4), .V_BLANK(3), .VS_LINES(1)
   ) u_dut16 (
      .clk(clk), .reset(reset2), .enable(enable2), .mode(mode2),
      .vsync(vsync2), .vsync_neg_flag(vsync_neg_flag2), .o_de(o_de2), .dout(dout2),
      .busy(busy2), .frame_done(frame_done2)
   );

   // Expected {busy, frame_done, vsync, vsync_neg_flag, o_de, dout} at frame clock c
   // (H_BLANK=4, V_BLANK=3, VS_LINES=1).
   function automatic logic [12:0] exp_out(int iw, int ih, int c, int m, logic [7:0] flat);
      int ht;
      int vt;
      int h;
      int v;
      logic de;
      logic [7:0] pix;
      ht = iw + 4;
      vt = ih + 3;
      h  = c % ht;
      v  = c / ht;
      de = (h < iw) && (v < ih);
      case (m)
         0:       pix = 8'(h);
         1:       pix = 8'(v);
         2:       pix = (((h ^ v) & 8) != 0) ? 8'hff : 8'h00;
         default: pix = flat;
      endcase
      return {1'b1, (c == ht * vt - 1), (v == ih), (v == ih + 1) && (h == 0), de,
              de ? pix : 8'h00};
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; mode = 2'd0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (obs1 !== 13'd0) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%h want=%h", i, obs1, 13'd0);
         end
         @(negedge clk);
      end
   endtask

   // First frame after reset, horizontal ramp; mode change mid-frame is ignored.
   task automatic test_ramp();
      int des;
      des = 0;
      reset = 1'b0; enable = 1'b1; mode = 2'd0;
      for (int c = 0; c < 84; c++) begin
         @(negedge clk);
         want = exp_out(8, 4, c, 0, 8'd0);
         des += int'(o_de);
         vectors++;
         if (obs1 !== want) begin
            errors++;
            $display("FAIL ramp c=%0d got=%h want=%h", c, obs1, want);
         end
         if (c == 40) mode = 2'd3;
      end
      vectors++;
      if (des != 32) begin
         errors++;
         $display("FAIL ramp_de_count got=%0d want=32", des);
      end
   endtask

   // Frames 2 and 3, flat pattern carrying the frame count, back-to-back.
   task automatic test_flat();
      for (int f = 1; f <= 2; f++) begin
         int flags;
         flags = 0;
         for (int c = 0; c < 84; c++) begin
            @(negedge clk);
            want = exp_out(8, 4, c, 3, 8'(f));
            flags += int'(vsync_neg_flag);
            vectors++;
            if (obs1 !== want) begin
               errors++;
               $display("FAIL flat f=%0d c=%0d got=%h want=%h", f, c, obs1, want);
            end
            if (f == 2 && c == 83) mode = 2'd0;
         end
         vectors++;
         if (flags != 1) begin
            errors++;
            $display("FAIL flat_negflag_count f=%0d got=%0d want=1", f, flags);
         end
      end
   endtask

   // Enable drops at line 1 h=3: frame still completes, then idle, then restart.
   task automatic test_stop();
      int des;
      des = 0;
      for (int c = 0; c < 84; c++) begin
         @(negedge clk);
         want = exp_out(8, 4, c, 0, 8'd0);
         des += int'(o_de);
         vectors++;
         if (obs1 !== want) begin
            errors++;
            $display("FAIL stop c=%0d got=%h want=%h", c, obs1, want);
         end
         if (c == 15) enable = 1'b0;
      end
      vectors++;
      if (des != 32) begin
         errors++;
         $display("FAIL stop_de_count got=%0d want=32", des);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (obs1 !== 13'd0) begin
            errors++;
            $display("FAIL stop_idle i=%0d got=%h want=%h", i, obs1, 13'd0);
         end
      end
      enable = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         want = exp_out(8, 4, c, 0, 8'd0);
         vectors++;
         if (obs1 !== want) begin
            errors++;
            $display("FAIL reenable c=%0d got=%h want=%h", c, obs1, want);
         end
      end
   endtask

   // Reset at line 2 h=5, then a full frame from h=v=0 (vertical ramp).
   task automatic test_reset_mid();
      reset = 1'b1;
      mode  = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (obs1 !== 13'd0) begin
            errors++;
            $display("FAIL midreset i=%0d got=%h want=%h", i, obs1, 13'd0);
         end
      end
      reset = 1'b0;
      for (int c = 0; c < 84; c++) begin
         @(negedge clk);
         want = exp_out(8, 4, c, 1, 8'd0);
         vectors++;
         if (obs1 !== want) begin
            errors++;
            $display("FAIL restart c=%0d got=%h want=%h", c, obs1, want);
         end
         if (c == 83) enable = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (obs1 !== 13'd0) begin
            errors++;
            $display("FAIL restart_idle i=%0d got=%h want=%h", i, obs1, 13'd0);
         end
      end
   endtask

   // 16x16 checkerboard; mode change mid-frame applies only to the next frame.
   task automatic test_checker();
      reset2 = 1'b0; enable2 = 1'b1; mode2 = 2'd2;
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c < 380; c++) begin
            @(negedge clk);
            want = exp_out(16, 16, c, (f == 0) ? 2 : 0, 8'd0);
            vectors++;
            if (obs2 !== want) begin
               errors++;
               $display("FAIL checker f=%0d c=%0d got=%h want=%h", f, c, obs2, want);
            end
            if (f == 0 && c == 100) mode2 = 2'd0;
            if (f == 1 && c == 0) enable2 = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (obs2 !== 13'd0) begin
            errors++;
            $display("FAIL checker_idle i=%0d got=%h want=%h", i, obs2, 13'd0);
         end
      end
   endtask

   initial begin
      reset2 = 1'b1; enable2 = 1'b0; mode2 = 2'd0;
      test_reset();
      test_ramp();
      test_flat();
      test_stop();
      test_reset_mid();
      test_checker();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
